// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Write-back store buffer sitting between the MEM stage and the single-port
// data memory. Stores from MEM are queued in program order and retired to the
// memory one per cycle, on cycles where MEM is not using the port for a load.
// Loads in MEM are forwarded from the youngest buffered store to the same word
// address, so the pipeline never observes stale memory contents.
//
// Optional build macro:
//   STBUF_COALESCE_EN - a store to the same word address as the youngest
//                       buffered entry overwrites that entry in place instead
//                       of allocating a new one (accepted even when full).
//
// Parameters:
//   DEPTH  number of buffered stores (power of two, >= 2)
//   AW     word-address width
//   DW     data width
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   st_valid/addr/data    store request from MEM
//   st_ready              store accepted this cycle
//   stall_req             store present but not accepted; hold the pipeline
//   ld_valid/addr         load request from MEM (owns the memory port)
//   ld_hit/ld_data        forwarded data from the youngest matching entry
//   dm_wr/addr/wdata      drain write port to data memory
//   empty/full/count      occupancy status
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  output logic                     stall_req,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     dm_wr,
  output logic [AW-1:0]            dm_addr,
  output logic [DW-1:0]            dm_wdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage carries no reset: validity is defined purely by head/count.
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_drain;
  logic          w_coal;
  logic          w_enq;
  logic          w_hit;
  logic [DW-1:0] w_fwd_data;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

  // A load owns the memory port, so it blocks retirement for that cycle.
  assign w_drain  = !empty && !ld_valid;
  assign dm_wr    = w_drain;
  assign dm_addr  = r_addr[r_head];
  assign dm_wdata = r_data[r_head];

`ifdef STBUF_COALESCE_EN
  logic [PW-1:0] w_young;
  assign w_young = r_tail - PW'(1);
  // Merge into the youngest entry unless that entry is the one leaving this
  // cycle (count==1 and draining); then a fresh entry is allocated instead.
  assign w_coal  = st_valid && !empty && (r_addr[w_young] == st_addr) &&
                   !((w_young == r_head) && w_drain);
`else
  assign w_coal  = 1'b0;
`endif

  // A draining slot frees room for a store in the same cycle.
  assign st_ready  = !full || w_drain || w_coal;
  assign stall_req = st_valid && !st_ready;
  assign w_enq     = st_valid && st_ready && !w_coal;

  // Scan oldest to youngest so the last match written wins (youngest store).
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_addr[r_head + PW'(i)] == ld_addr)) begin
        w_hit      = 1'b1;
        w_fwd_data = r_data[r_head + PW'(i)];
      end
    end
  end

  // Simultaneous store and load is treated as store-only: no forwarding.
  assign ld_hit  = ld_valid && !st_valid && w_hit;
  assign ld_data = ld_hit ? w_fwd_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) r_head <= r_head + PW'(1);
      if (w_enq)   r_tail <= r_tail + PW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_drain);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
`ifdef STBUF_COALESCE_EN
    if (w_coal) r_data[w_young] <= st_data;
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 7;
  localparam int DW    = 32;

  logic          clk;
  logic          rst;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          stall_req;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          empty;
  logic          full;
  logic [2:0]    count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .stall_req(stall_req),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .empty(empty), .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];     // model: buffered stores, oldest first
  ent_t wlog[$];  // memory writes observed from the DUT

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model rules: drain whenever something is buffered and no load is present;
  // a store is taken if there is a free slot, a slot is being freed, or it
  // merges into the youngest entry (coalescing build only).
  function automatic void model_ctl(output bit drn, output bit coal, output bit rdy);
    int n;
    n    = q.size();
    drn  = (n > 0) && !ld_valid;
    coal = 1'b0;
`ifdef STBUF_COALESCE_EN
    coal = st_valid && (n > 0) && (q[n-1].a == st_addr) && !((n == 1) && drn);
`endif
    rdy  = (n < DEPTH) || drn || coal;
  endfunction

  // Compare process: all outputs every cycle outside reset.
  always @(negedge clk) begin
    bit drn, coal, rdy, hit;
    logic [DW-1:0] hd;
    int n;
    if (!rst) begin
      model_ctl(drn, coal, rdy);
      n   = q.size();
      hit = 1'b0;
      hd  = '0;
      if (ld_valid && !st_valid)
        for (int i = n - 1; i >= 0; i--)
          if (!hit && q[i].a == ld_addr) begin
            hit = 1'b1;
            hd  = q[i].d;
          end
      chk("dm_wr", 64'(dm_wr), 64'(drn));
      if (drn) begin
        chk("dm_addr", 64'(dm_addr), 64'(q[0].a));
        chk("dm_wdata", 64'(dm_wdata), 64'(q[0].d));
      end
      chk("st_ready", 64'(st_ready), 64'(rdy));
      chk("stall_req", 64'(stall_req), 64'(st_valid && !rdy));
      chk("ld_hit", 64'(ld_hit), 64'(hit));
      chk("ld_data", 64'(ld_data), 64'(hd));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("full", 64'(full), 64'(n == DEPTH));
      chk("count", 64'(count), 64'(n));
      if (dm_wr) wlog.push_back({dm_addr, dm_wdata});
    end
  end

  // Model state update.
  always @(posedge clk or posedge rst) begin
    bit drn, coal, rdy;
    if (rst) begin
      q.delete();
    end else begin
      model_ctl(drn, coal, rdy);
      if (coal) q[q.size()-1].d = st_data;
      if (drn) void'(q.pop_front());
      if (st_valid && rdy && !coal) q.push_back({st_addr, st_data});
    end
  end

  task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input logic lv, input logic [AW-1:0] la);
    @(posedge clk);
    #1;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (idx < wlog.size()) begin
      chk({nm, "_addr"}, 64'(wlog[idx].a), 64'(a));
      chk({nm, "_data"}, 64'(wlog[idx].d), 64'(d));
    end else begin
      chk({nm, "_missing"}, 64'(wlog.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dm_wr", 64'(dm_wr), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single store, retired on the following edge.
    wlog.delete();
    step(1'b1, 7'd5, 32'hDEADBEEF, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, '0);
    at_neg();
    chk("t1_dm_wr", 64'(dm_wr), 64'd1);
    chk("t1_dm_addr", 64'(dm_addr), 64'd5);
    chk("t1_dm_wdata", 64'(dm_wdata), 64'hDEADBEEF);
    step(1'b0, '0, '0, 1'b0, '0);
    at_neg();
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_nwrites", 64'(wlog.size()), 64'd1);

    // Fill while a load blocks the port, stall the 5th, release on drain.
    wlog.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, 7'(i), 32'h100 + 32'(i), 1'b1, 7'd9);
    step(1'b1, 7'd5, 32'h105, 1'b1, 7'd9);
    at_neg();
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_count", 64'(count), 64'd4);
    chk("t2_stall", 64'(stall_req), 64'd1);
    chk("t2_no_wr", 64'(dm_wr), 64'd0);
    step(1'b1, 7'd5, 32'h105, 1'b1, 7'd9);
    step(1'b1, 7'd5, 32'h105, 1'b0, '0);
    at_neg();
    chk("t2_accept", 64'(st_ready), 64'd1);
    chk("t2_stall_off", 64'(stall_req), 64'd0);
    step(1'b0, '0, '0, 1'b0, '0);
    at_neg();
    chk("t2_count_hold", 64'(count), 64'd4);
    idle(5);
    chk("t2_nwrites", 64'(wlog.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk_log("t2_wr", i, 7'(i + 1), 32'h101 + 32'(i));

    // Forwarding from the youngest of two stores to the same address.
    wlog.delete();
    step(1'b1, 7'd7, 32'h11, 1'b1, 7'd8);
    step(1'b1, 7'd7, 32'h22, 1'b1, 7'd8);
    step(1'b0, '0, '0, 1'b1, 7'd7);
    at_neg();
    chk("t3_hit", 64'(ld_hit), 64'd1);
    chk("t3_data", 64'(ld_data), 64'h22);
`ifdef STBUF_COALESCE_EN
    chk("t3_count", 64'(count), 64'd1);
`else
    chk("t3_count", 64'(count), 64'd2);
`endif
    step(1'b0, '0, '0, 1'b1, 7'd8);
    at_neg();
    chk("t3_miss", 64'(ld_hit), 64'd0);
    chk("t3_miss_data", 64'(ld_data), 64'd0);
    idle(4);

    // Wrap-around: stores interleaved with loads, drains in order.
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 7'(20 + i), 32'h200 + 32'(i), 1'b0, '0);
      step(1'b0, '0, '0, 1'b1, 7'(20 + i));
    end
    idle(5);
    chk("t4_nwrites", 64'(wlog.size()), 64'd10);
    for (int i = 0; i < 10; i++) chk_log("t4_wr", i, 7'(20 + i), 32'h200 + 32'(i));

    // Asynchronous reset with three pending stores.
    wlog.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 7'(40 + i), 32'h300 + 32'(i), 1'b1, 7'd9);
    step(1'b0, '0, '0, 1'b1, 7'd41);
    at_neg();
    chk("t5_count_pre", 64'(count), 64'd3);
    chk("t5_hit_pre", 64'(ld_hit), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_empty", 64'(empty), 64'd1);
    chk("t5_dm_wr", 64'(dm_wr), 64'd0);
    chk("t5_ld_hit", 64'(ld_hit), 64'd0);
    chk("t5_ld_data", 64'(ld_data), 64'd0);
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("t5_nwrites", 64'(wlog.size()), 64'd0);

    // Back-to-back stores to one address while a load blocks drain.
    wlog.delete();
    step(1'b1, 7'd3, 32'hA, 1'b1, 7'd9);
    step(1'b1, 7'd3, 32'hB, 1'b1, 7'd9);
    step(1'b0, '0, '0, 1'b1, 7'd9);
    at_neg();
`ifdef STBUF_COALESCE_EN
    chk("t6_count", 64'(count), 64'd1);
    idle(3);
    chk("t6_nwrites", 64'(wlog.size()), 64'd1);
    chk_log("t6_wr", 0, 7'd3, 32'hB);
`else
    chk("t6_count", 64'(count), 64'd2);
    idle(3);
    chk("t6_nwrites", 64'(wlog.size()), 64'd2);
    chk_log("t6_wr0", 0, 7'd3, 32'hA);
    chk_log("t6_wr1", 1, 7'd3, 32'hB);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
